// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef logic [31:0] word32_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic    read;
    logic    write;
    word32_t addr;
    word32_t data;
  } mem_req_t;

  localparam int NUM_PORTS = 2;

  // A port is asking for service when either strobe is up.
  function automatic logic req_active(input mem_req_t r);
    return r.read | r.write;
  endfunction

  // Read and write together is a requester bug; resolve it as a plain write.
  function automatic mem_req_t req_normalize(input mem_req_t r);
    mem_req_t n;
    n       = r;
    n.read  = r.read & ~r.write;
    return n;
  endfunction

endpackage

// File: rtl/dmem_arbiter_pick2.sv
// Combinational two-way picker: round-robin or fixed priority with a
// force input that hands a tie to port 1.
module arb_pick2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       rr_ptr,    // preferred port on a tie in round-robin mode
  input  logic       force_p1,  // fixed mode: port 1 takes the next tie
  output logic       valid,
  output logic       winner
);

  // Resolve the winner from the request vector; ties use the mode's rule.
  always_comb begin
    valid  = 1'b0;
    winner = 1'b0;
    case (req)
      2'b01: begin
        valid  = 1'b1;
        winner = 1'b0;
      end
      2'b10: begin
        valid  = 1'b1;
        winner = 1'b1;
      end
      2'b11: begin
        valid  = 1'b1;
        winner = FIXED_PRIO ? force_p1 : rr_ptr;
      end
      default: begin
        valid  = 1'b0;
        winner = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of one unified data-memory port. One transaction
// at a time: the winner's op/address/data are latched and held on the memory
// port until mem_done_i, then the arbiter returns to IDLE for one cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        req_read_i,
  input  logic [1:0]        req_write_i,
  input  word32_t [1:0]     req_addr_i,
  input  word32_t [1:0]     req_data_i,
  output word32_t           rd_data_o,
  output logic [1:0]        done_o,
  input  word32_t           mem_rd_data_i,
  input  logic              mem_done_i,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output word32_t           mem_addr_o,
  output word32_t           mem_data_o
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  arb_state_t           state_r;
  arb_state_t           state_nx_s;
  mem_req_t             cur_r;
  logic                 grant_r;
  logic                 rr_ptr_r;
  logic [3:0]           wait_cnt_r;

  mem_req_t             port_req_s [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_vec_s;
  logic                 pick_valid_s;
  logic                 pick_winner_s;
  logic                 force_p1_s;
  logic                 grant_s;
  logic                 done_fire_s;

  // Pack each port's raw inputs into request structs.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_req_s[p] = '{read: req_read_i[p], write: req_write_i[p],
                        addr: req_addr_i[p], data: req_data_i[p]};
      req_vec_s[p]  = req_active(port_req_s[p]);
    end
  end

  assign force_p1_s  = (wait_cnt_r == WAIT_LIMIT);
  assign grant_s     = (state_r == ARB_IDLE) & pick_valid_s;
  // Reset in the completion cycle abandons the access, so no done is issued.
  assign done_fire_s = (state_r == ARB_BUSY) & mem_done_i & ~reset_i;

  arb_pick2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req      (req_vec_s),
    .rr_ptr   (rr_ptr_r),
    .force_p1 (force_p1_s),
    .valid    (pick_valid_s),
    .winner   (pick_winner_s)
  );

  // Next-state logic: IDLE waits for a request, BUSY waits for memory.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) state_nx_s = ARB_BUSY;
        else              state_nx_s = ARB_IDLE;
      end
      ARB_BUSY: begin
        if (mem_done_i) state_nx_s = ARB_IDLE;
        else            state_nx_s = ARB_BUSY;
      end
      default: state_nx_s = ARB_IDLE;
    endcase
  end

  // State, latched transaction and fairness bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= ARB_IDLE;
      cur_r      <= '0;
      grant_r    <= 1'b0;
      rr_ptr_r   <= 1'b0;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      if (grant_s) begin
        grant_r  <= pick_winner_s;
        cur_r    <= req_normalize(port_req_s[pick_winner_s]);
        rr_ptr_r <= ~pick_winner_s;
        if (pick_winner_s) begin
          wait_cnt_r <= 4'd0;
        end else if (req_vec_s[1] && (wait_cnt_r != 4'hF)) begin
          wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
          wait_cnt_r <= wait_cnt_r;
        end
      end else if (done_fire_s) begin
        // Drop the strobes (and stale address/data) for the idle gap.
        cur_r <= '0;
      end else begin
        cur_r <= cur_r;
      end
    end
  end

  assign mem_read_o  = cur_r.read;
  assign mem_write_o = cur_r.write;
  assign mem_addr_o  = cur_r.addr;
  assign mem_data_o  = cur_r.data;

  // Completion pulse and load data; both zero outside the done cycle so the
  // read-data bus can be OR-combined downstream.
  always_comb begin
    done_o    = 2'b00;
    rd_data_o = 32'h0000_0000;
    if (done_fire_s) begin
      done_o[grant_r] = 1'b1;
      rd_data_o       = mem_rd_data_i;
    end else begin
      done_o    = 2'b00;
      rd_data_o = 32'h0000_0000;
    end
  end

endmodule
